// File: rtl/addsub_pkg.sv
// Shared definitions for the AddSub round-robin arbiter.
package addsub_pkg;

  localparam logic ADD = 1'b0;
  localparam logic SUB = 1'b1;

  // Largest supported requester count and matching index width.
  localparam int unsigned MAX_REQ = 8;
  localparam int unsigned MAX_IDW = 3;

  // One-hot round-robin winner: first set req bit above last_ptr, wrapping modulo n.
  function automatic logic [MAX_REQ-1:0] rr_pick(
    input logic [MAX_REQ-1:0] req,
    input logic [MAX_IDW-1:0] last_ptr,
    input int unsigned        n
  );
    logic [MAX_REQ-1:0] pick;
    logic [MAX_IDW-1:0] idx;
    logic               found;
    pick  = '0;
    found = 1'b0;
    for (int unsigned k = 1; k <= MAX_REQ; k++) begin
      idx = MAX_IDW'((32'(last_ptr) + k) % n);
      if (!found && (k <= n) && req[idx]) begin
        pick[idx] = 1'b1;
        found     = 1'b1;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/addsub_rr_arbiter_addsub.sv
// Combinational W-bit add/subtract with carry out and signed overflow.
module addsub_rr_arbiter_addsub #(
  parameter int unsigned W = 8
) (
  input  logic [W-1:0] A,
  input  logic [W-1:0] B,
  input  logic         Ci,
  output logic [W-1:0] SD,
  output logic         Co,
  output logic         Err
);

  logic [W-1:0] bx;

  // Subtract is A + ~B + 1; overflow when like-signed inputs give an unlike-signed result.
  always_comb begin
    bx        = Ci ? ~B : B;
    {Co, SD}  = (W+1)'(A) + (W+1)'(bx) + (W+1)'(Ci);
    Err       = (A[W-1] == bx[W-1]) && (SD[W-1] != A[W-1]);
  end

endmodule

// File: rtl/addsub_rr_arbiter.sv
// Round-robin arbiter sharing one AddSub datapath among NUM_REQ requesters.
module addsub_rr_arbiter
  import addsub_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned W       = 8,
  parameter int unsigned IDW     = $clog2(NUM_REQ)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [NUM_REQ*W-1:0] a_flat,
  input  logic [NUM_REQ*W-1:0] b_flat,
  input  logic [NUM_REQ-1:0]   sub,
  output logic [NUM_REQ-1:0]   gnt,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [IDW-1:0]       rsp_id,
  output logic [W-1:0]         rsp_sd,
  output logic                 rsp_co,
  output logic                 rsp_err
);

  logic [IDW-1:0]     last_ptr;
  logic               can_accept_c;
  logic [MAX_REQ-1:0] pick_c;
  logic [IDW-1:0]     win_idx_c;
  logic [W-1:0]       a_sel_c;
  logic [W-1:0]       b_sel_c;
  logic               ci_sel_c;
  logic [W-1:0]       sd_c;
  logic               co_c;
  logic               err_c;

  // Arbitration, winner index and operand mux.
  always_comb begin
    can_accept_c = !rsp_valid || rsp_ready;
    pick_c       = rr_pick(MAX_REQ'(req), MAX_IDW'(last_ptr), NUM_REQ);
    win_idx_c    = '0;
    a_sel_c      = '0;
    b_sel_c      = '0;
    ci_sel_c     = ADD;
    for (int i = 0; i < MAX_REQ; i++) begin
      if (pick_c[i]) win_idx_c = IDW'(i);
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      if (pick_c[i]) begin
        a_sel_c  = a_flat[i*W +: W];
        b_sel_c  = b_flat[i*W +: W];
        ci_sel_c = (sub[i] == SUB);
      end
    end
    gnt = (rst_n && can_accept_c) ? pick_c[NUM_REQ-1:0] : '0;
  end

  addsub_rr_arbiter_addsub #(.W(W)) u_addsub (
    .A   (a_sel_c),
    .B   (b_sel_c),
    .Ci  (ci_sel_c),
    .SD  (sd_c),
    .Co  (co_c),
    .Err (err_c)
  );

  // Response register and round-robin pointer.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_sd    <= '0;
      rsp_co    <= 1'b0;
      rsp_err   <= 1'b0;
      last_ptr  <= IDW'(NUM_REQ - 1);
    end else if (|gnt) begin
      rsp_valid <= 1'b1;
      rsp_id    <= win_idx_c;
      rsp_sd    <= sd_c;
      rsp_co    <= co_c;
      rsp_err   <= err_c;
      last_ptr  <= win_idx_c;
    end else if (rsp_ready) begin
      rsp_valid <= 1'b0;
    end
  end

endmodule
